// File: rtl/nanci_row_drain.sv
// Row drain for the Nanci PE mesh: snapshots one row of o_PE words on a capture
// pulse and streams them out one per valid/ready transfer, optionally in reverse.
module nanci_row_drain #(
    parameter int ROW_PES    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int REVERSE    = 0,
    parameter int IDX_W      = (ROW_PES > 1) ? $clog2(ROW_PES) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_capture,
    input  logic [ROW_PES*(ADDR_WIDTH+DATA_WIDTH)-1:0]  i_PE_row,
    input  logic                                        i_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]            o_data,
    output logic [IDX_W-1:0]                            o_index,
    output logic                                        o_valid,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic                                        o_overrun
);

    localparam int W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [IDX_W-1:0] START_IDX = (REVERSE != 0) ? IDX_W'(ROW_PES - 1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = (REVERSE != 0) ? IDX_W'(0) : IDX_W'(ROW_PES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             load_s;
    logic [W-1:0]     snap_q [ROW_PES];

    // Next-state logic: capture, index stepping, last-transfer and overrun handling
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    load_s  = 1'b1;
                    idx_d   = START_IDX;
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (i_ready && (idx_q == LAST_IDX)) begin
                    // A capture on the final handshake restarts without a bubble
                    done_d = 1'b1;
                    if (i_capture) begin
                        load_s = 1'b1;
                        idx_d  = START_IDX;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (i_ready) begin
                        idx_d = (REVERSE != 0) ? (idx_q - ONE_IDX) : (idx_q + ONE_IDX);
                    end else begin
                        idx_d = idx_q;
                    end
                    if (i_capture) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index, flags and snapshot bank registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < ROW_PES; k++) begin
                snap_q[k] <= {W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            if (load_s) begin
                for (int k = 0; k < ROW_PES; k++) begin
                    snap_q[k] <= i_PE_row[k*W +: W];
                end
            end
        end
    end

    assign o_data    = snap_q[idx_q];
    assign o_index   = idx_q;
    assign o_valid   = (state_q == DRAIN);
    assign o_busy    = (state_q == DRAIN);
    assign o_done    = done_q;
    assign o_overrun = overrun_q;

endmodule

// File: doc/nanci_row_drain.md
Name: nanci_row_drain

Overview:
Downstream stage of the Nanci PE mesh. Snapshots the o_PE words of one row of PEs when the sort/compute phases finish, then streams them out one word per transfer over a valid/ready handshake. Supports snake-order rows: odd rows of the shear-sort mesh are drained in reverse PE order, so the concatenated stream across rows comes out globally sorted.

Parameters:
ROW_PES, 4, number of PEs in the row (SQRT_N of the mesh); legal range >= 1
ADDR_WIDTH, 3, PE address field width; same value as the PE instances
DATA_WIDTH, 3, PE data field width; same value as the PE instances
REVERSE, 0, 0 = drain PE 0 first; 1 = drain PE ROW_PES-1 first (snake row)
IDX_W, max(1,clog2(ROW_PES)), width of o_index; derived, not overridden

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
i_capture  in  1  one-cycle pulse: snapshot i_PE_row and start draining
i_PE_row  in  ROW_PES*(ADDR_WIDTH+DATA_WIDTH)  PE word k is at bits [k*W +: W], where W = ADDR_WIDTH+DATA_WIDTH
i_ready  in  1  consumer accepts o_data this cycle
o_data  out  W  current word, bit-identical to the PE's o_PE
o_index  out  IDX_W  PE index (0..ROW_PES-1) of the current o_data
o_valid  out  1  o_data/o_index hold a valid word
o_busy  out  1  high while in DRAIN
o_done  out  1  one-cycle pulse after the last word's handshake
o_overrun  out  1  sticky: a capture was ignored; cleared only by rst

Behaviour:
- Reset (rst=1 at an edge) drives all outputs to 0 on that edge, sets the state to IDLE and clears the snapshot bank.
  - Reset wins over every other input in the same cycle.
  - Reset mid-drain aborts the drain; no o_done pulse is produced.
- States: IDLE, DRAIN. A transfer happens on an edge where o_valid && i_ready.
- IDLE:
  - o_valid=0, o_busy=0.
  - On i_capture=1: latch all ROW_PES words into the snapshot bank, set idx to the start index (0, or ROW_PES-1 when REVERSE=1), then enter DRAIN.
  - Latency: o_valid=1 and o_busy=1 in the cycle after the capture edge.
  - i_ready is ignored in IDLE.
- DRAIN:
  - o_valid=1.
  - o_data = snapshot[idx], o_index = idx.
  - Both are held stable while i_ready=0; no limit on stall length.
  - On a transfer that is not the last, idx steps +1 (or -1 when REVERSE=1).
  - On the last transfer (idx = ROW_PES-1, or 0 when REVERSE=1), o_done=1 for the next cycle only, and:
    - if i_capture=0 on that edge: go to IDLE; o_valid and o_busy drop to 0.
    - if i_capture=1 on that same edge: re-snapshot i_PE_row, reset idx to the start index and stay in DRAIN. o_done still pulses, and o_valid stays 1 with no bubble.
  - i_capture=1 in DRAIN on any edge other than the last transfer: ignored, o_overrun set to 1. The snapshot is unaffected.
- ROW_PES=1: a single word; the start index equals the last index; o_index is constantly 0.
- The index never wraps: all idx arithmetic stays within 0..ROW_PES-1.
- Snapshot independence: changes on i_PE_row after the capture edge never reach o_data.
- The block is fully synchronous. There are no combinational paths from i_ready or i_capture to any output.

Test Plan:
- Reset: hold rst for 2 cycles with i_capture=1 and i_ready=1 -> o_valid=0, o_busy=0, o_done=0, o_overrun=0, o_data=0 throughout.
- Forward drain (ROW_PES=4, W=6): i_PE_row={6'o43,6'o32,6'o21,6'o10}, capture pulse, i_ready=1 -> next 4 cycles o_data=8,17,26,35 with o_index=0,1,2,3. o_done=1 in cycle 5 only, o_valid=0 from cycle 5.
- Snake drain (REVERSE=1): same stimulus -> o_data=35,26,17,8 with o_index=3,2,1,0. Then o_done pulses.
- Backpressure: i_ready toggles 0,0,1,0,1,1,1 -> each word is held until accepted; no word lost or duplicated. i_PE_row is changed to all ones after capture and never appears on o_data.
- Overrun and back-to-back:
  - i_capture during the 2nd word -> o_overrun=1 and the output stream is unchanged.
  - i_capture on the last-transfer edge -> a new row of 4 words follows with o_valid continuous and o_done pulsed once.
- Mid-drain reset: rst asserted after 2 transfers -> outputs are 0 on the next cycle and o_done never pulses. A fresh capture then drains all 4 words correctly from index 0.
